// File: rtl/fsm_delay_counter_pkg.sv
// fsm_delay_counter_pkg: shared defaults and run-mode type for the delay timer
//   CNT_W_DEF    width of countVal and of the unit counter
//   TICK_DIV_DEF clock cycles per time unit in the real system
//   TICK_DIV_SIM short time unit used in simulation
package fsm_delay_counter_pkg;
  localparam int CNT_W_DEF = 3;
  localparam int TICK_DIV_DEF = 50000000;
  localparam int TICK_DIV_SIM = 4;
  typedef enum logic {IDLE, RUN} mode_e;
endpackage

// File: rtl/fsm_tick_gen.sv
// fsm_tick_gen: prescaler that divides clock into time-unit ticks
//   clock  system clock, posedge
//   reset  asynchronous active-low reset
//   clr    synchronous clear of prescaler and tick
//   en     advance the prescaler this cycle
//   tick   registered one-cycle pulse at each unit boundary
//   wrap   high while the prescaler sits on its last cycle of a unit
module fsm_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick,
  output logic wrap
);
  localparam int PW = $clog2(TICK_DIV);
  logic [PW-1:0] p;
  // wrap lets the counter step on the same edge that raises tick
  assign wrap = p == PW'(TICK_DIV - 1);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      p <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      p <= '0;
      tick <= 1'b0;
    end else if (en) begin
      p <= wrap ? '0 : p + PW'(1);
      tick <= wrap;
    end else
      tick <= 1'b0;
endmodule

// File: rtl/fsm_delay_counter.sv
// fsm_delay_counter: delay timer that raises contBETval after countVal time units
//   clock       system clock, posedge
//   reset       asynchronous active-low reset
//   initCount   1 = run/hold timing, 0 = clear and idle
//   countVal    target unit count
//   hold        (FSM_CNT_HOLD_EN only) freeze timing while in RUN
//   contBETval  count >= target, gated by initCount and an unchanged target
//   count       elapsed units since last restart, saturating
//   tick        one-cycle pulse at each unit boundary
// Optional macro FSM_CNT_HOLD_EN adds the hold input.
module fsm_delay_counter
  import fsm_delay_counter_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic initCount,
  input  logic [CNT_W-1:0] countVal,
`ifdef FSM_CNT_HOLD_EN
  input  logic hold,
`endif
  output logic contBETval,
  output logic [CNT_W-1:0] count,
  output logic tick
);
  mode_e mode;
  logic [CNT_W-1:0] cv_q, count_next;
  logic cbv_q, restart, adv, wrap;
  assign mode = initCount ? RUN : IDLE;
  assign restart = mode == RUN && countVal != cv_q;
`ifdef FSM_CNT_HOLD_EN
  assign adv = mode == RUN && !restart && !hold;
`else
  assign adv = mode == RUN && !restart;
`endif
  assign count_next = (wrap && count != '1) ? count + CNT_W'(1) : count;
  // gating hides a stale cbv_q in the cycle the FSM changes target
  assign contBETval = cbv_q && mode == RUN && countVal == cv_q;
  fsm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock(clock),
    .reset(reset),
    .clr(mode == IDLE || restart),
    .en(adv),
    .tick(tick),
    .wrap(wrap)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      count <= '0;
      cv_q <= '0;
      cbv_q <= 1'b0;
    end else if (mode == IDLE) begin
      count <= '0;
      cv_q <= countVal;
      cbv_q <= 1'b0;
    end else if (restart) begin
      count <= '0;
      cv_q <= countVal;
      cbv_q <= countVal == '0;
    end else if (adv) begin
      count <= count_next;
      cbv_q <= count_next >= cv_q;
    end
endmodule

// File: tb/tb_fsm_delay_counter.sv
// tb_fsm_delay_counter: random and directed checks against an elapsed-cycle model
module tb_fsm_delay_counter;
  localparam int TD = 4;
  localparam int CW = 3;
  localparam int MAXC = (1 << CW) - 1;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic initCount = 1'b0;
  logic [CW-1:0] countVal = '0;
  logic hold = 1'b0;
  logic contBETval, tick;
  logic [CW-1:0] count;
  int ncmp = 0, nerr = 0;
  int e = 0, tgt = 0;
  logic tick_m = 1'b0, cbv_m = 1'b0;
  always #5 clock = ~clock;
  fsm_delay_counter #(.TICK_DIV(TD), .CNT_W(CW)) dut (
    .clock(clock),
    .reset(reset),
    .initCount(initCount),
    .countVal(countVal),
`ifdef FSM_CNT_HOLD_EN
    .hold(hold),
`endif
    .contBETval(contBETval),
    .count(count),
    .tick(tick)
  );
  function automatic int units(int cycles);
    return (cycles / TD > MAXC) ? MAXC : cycles / TD;
  endfunction
  task automatic chk(string name, int got, int exp);
    ncmp++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask
  // model: e = cycles spent advancing since the last idle/restart edge
  always @(posedge clock or negedge reset)
    if (!reset) begin
      e = 0; tgt = 0; tick_m = 1'b0; cbv_m = 1'b0;
    end else if (!initCount) begin
      e = 0; tgt = int'(countVal); tick_m = 1'b0; cbv_m = 1'b0;
    end else if (int'(countVal) != tgt) begin
      e = 0; tgt = int'(countVal); tick_m = 1'b0; cbv_m = (tgt == 0);
    end else if (hold) begin
      tick_m = 1'b0;
    end else begin
      e++;
      tick_m = (e % TD == 0);
      cbv_m = units(e) >= tgt;
    end
  always @(negedge clock) begin
    chk("count", int'(count), units(e));
    chk("tick", int'(tick), int'(tick_m));
    chk("contBETval", int'(contBETval), int'(cbv_m && initCount && int'(countVal) == tgt));
  end
  task automatic cyc(int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask
  initial begin
    #3;
    chk("rst_count", int'(count), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_cbv", int'(contBETval), 0);
    cyc(2);
    reset = 1'b1;
    countVal = 3'd5;
    cyc(2);
    initCount = 1'b1;
    cyc(19);
    chk("basic_19_cbv", int'(contBETval), 0);
    chk("basic_19_cnt", int'(count), 4);
    cyc(1);
    chk("basic_20_cbv", int'(contBETval), 1);
    chk("basic_20_cnt", int'(count), 5);
    chk("basic_20_tick", int'(tick), 1);
    cyc(3);
    chk("basic_hold_cbv", int'(contBETval), 1);
    countVal = 3'd2;
    #1;
    chk("handoff_gate", int'(contBETval), 0);
    cyc(8);
    chk("handoff_8_cbv", int'(contBETval), 0);
    cyc(1);
    chk("handoff_9_cbv", int'(contBETval), 1);
    chk("handoff_9_cnt", int'(count), 2);
    initCount = 1'b0;
    countVal = 3'd7;
    cyc(1);
    initCount = 1'b1;
    cyc(160);
    chk("sat_cnt", int'(count), 7);
    chk("sat_cbv", int'(contBETval), 1);
    cyc(5);
    chk("sat_cnt2", int'(count), 7);
    initCount = 1'b0;
    countVal = 3'd0;
    cyc(1);
    initCount = 1'b1;
    #1;
    chk("t0_pre", int'(contBETval), 0);
    cyc(1);
    chk("t0_edge1", int'(contBETval), 1);
    initCount = 1'b0;
    #1;
    chk("idle_gate", int'(contBETval), 0);
    cyc(1);
    chk("idle_cnt", int'(count), 0);
    countVal = 3'd3;
    cyc(1);
    initCount = 1'b1;
    cyc(13);
    chk("mid_cnt", int'(count), 3);
    #1 reset = 1'b0;
    #1;
    chk("arst_cnt", int'(count), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_cbv", int'(contBETval), 0);
    cyc(2);
    reset = 1'b1;
    for (int i = 0; i < 600; i++) begin
      cyc(1);
      initCount = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 11) == 0) countVal = CW'($urandom_range(0, MAXC));
`ifdef FSM_CNT_HOLD_EN
      hold = ($urandom_range(0, 5) == 0);
`endif
      if ($urandom_range(0, 199) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end
    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
